// File: rtl/alarm_countdown_timer_if.sv
// Signal bundle between the alarm control FSM and the countdown timer.
// The pause input exists only when ALARM_TIMER_PAUSE_EN is defined.
interface alarm_countdown_timer_if;
    logic       start_timer;
    logic [3:0] value;
`ifdef ALARM_TIMER_PAUSE_EN
    logic       pause;
`endif
    logic       expired;
    logic       one_hz_enable;
    logic       half_hz_enable;
    logic [3:0] value_display;
    logic [1:0] state_dbg;

    // Level-sampled controls: start_timer/value (and pause) are taken on every rising clock
    // edge with no handshake; expired and the enables are single-cycle strobes with no back-pressure.
`ifdef ALARM_TIMER_PAUSE_EN
    modport master (output start_timer, value, pause,
                    input  expired, one_hz_enable, half_hz_enable, value_display, state_dbg);
    modport slave  (input  start_timer, value, pause,
                    output expired, one_hz_enable, half_hz_enable, value_display, state_dbg);
`else
    modport master (output start_timer, value,
                    input  expired, one_hz_enable, half_hz_enable, value_display, state_dbg);
    modport slave  (input  start_timer, value,
                    output expired, one_hz_enable, half_hz_enable, value_display, state_dbg);
`endif
endinterface

// File: rtl/alarm_countdown_timer.sv
// Seconds countdown timer with free-running 1 Hz / 0.5 Hz strobes.
// Optional countdown hold input enabled by defining ALARM_TIMER_PAUSE_EN.
module alarm_countdown_timer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic                   clock,
    input  logic                   reset,
    alarm_countdown_timer_if.slave tmr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] base_cnt_q, base_cnt_d;
    logic             half_phase_q, half_phase_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]       remaining_q, remaining_d;
    state_t           state_q, state_d;
    logic             one_hz;
    logic             hold;

`ifdef ALARM_TIMER_PAUSE_EN
    assign hold = tmr.pause;
`else
    assign hold = 1'b0;
`endif

    // Base strobes depend only on reset, never on start_timer or pause.
    always_comb begin
        one_hz       = (base_cnt_q == LAST);
        base_cnt_d   = one_hz ? '0 : base_cnt_q + 1'b1;
        half_phase_d = half_phase_q ^ one_hz;
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                if (!hold) begin
                    if (tick_cnt_q == LAST) begin
                        tick_cnt_d  = '0;
                        remaining_d = (remaining_q != 4'd0) ? 4'(remaining_q - 4'd1) : 4'd0;
                        if (remaining_q <= 4'd1) state_d = S_DONE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                remaining_d = 4'd0;
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = 4'd0;
            end
        endcase
        // A restart overrides whatever the state logic chose, in every state.
        if (tmr.start_timer) begin
            tick_cnt_d = '0;
            if (tmr.value != 4'd0) begin
                state_d     = S_RUN;
                remaining_d = tmr.value;
            end else begin
                state_d     = S_DONE;
                remaining_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_cnt_q   <= '0;
            half_phase_q <= 1'b0;
            tick_cnt_q   <= '0;
            remaining_q  <= 4'd0;
            state_q      <= S_IDLE;
        end else begin
            base_cnt_q   <= base_cnt_d;
            half_phase_q <= half_phase_d;
            tick_cnt_q   <= tick_cnt_d;
            remaining_q  <= remaining_d;
            state_q      <= state_d;
        end
    end

    assign tmr.expired        = (state_q == S_DONE);
    assign tmr.one_hz_enable  = one_hz;
    assign tmr.half_hz_enable = one_hz & half_phase_q;
    assign tmr.value_display  = remaining_q;
    assign tmr.state_dbg      = state_q;
endmodule
